pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the five-stage MIPS core, replacing per-stage hand-written F/D, D/E, E/M, M/W registers. Carries PC, instruction, a generic payload, a valid bit, the delay-slot flag and an exception code. Supports stall (hold) and flush (bubble insertion), with an option to keep the PC in the bubble for EPC generation. Saturating stall and bubble counters support performance debugging.

---
 rtl/pipe_stage_reg.sv | 113 +++++++++++
 tb/tb_pipe_stage_reg.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register for the MIPS core.
// Carries PC, instruction, payload, valid, delay-slot flag and exception code
// from one stage to the next, with stall (hold) and flush (bubble) control.
// Saturating counters record stalled cycles and bubbles loaded.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   stall, flush          hold contents / load a bubble (flush wins)
//   keep_pc               bubble keeps in_pc/in_bd instead of RESET_PC/0
//   cnt_clr               synchronous clear of both counters
//   in_*                  upstream slot (valid, pc, instr, data, bd, exc)
//   out_*                 registered slot
//   stall_cnt, bubble_cnt saturating performance counters
module pipe_stage_reg #(
  parameter int unsigned DATA_W    = 64,
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              keep_pc,
  input  logic              cnt_clr,
  input  logic              in_valid,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_bd,
  input  logic [4:0]        in_exc,
  output logic              out_valid,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_bd,
  output logic [4:0]        out_exc,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic              r_valid;
  logic [31:0]       r_pc;
  logic [31:0]       r_instr;
  logic [DATA_W-1:0] r_data;
  logic              r_bd;
  logic [4:0]        r_exc;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic w_load;
  logic w_stall_inc;
  logic w_bubble_inc;

  assign w_load       = !flush && !stall;
  assign w_stall_inc  = stall && !flush;
  // An invalid upstream slot loaded as-is is itself a bubble.
  assign w_bubble_inc = flush || (w_load && !in_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_pc         <= RESET_PC;
      r_instr      <= NOP_INSTR;
      r_data       <= '0;
      r_bd         <= 1'b0;
      r_exc        <= 5'd0;
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
        r_instr <= NOP_INSTR;
        r_data  <= '0;
        r_exc   <= 5'd0;
        // Keeping the PC lets the exception logic form EPC from the bubble.
        r_pc    <= keep_pc ? in_pc : RESET_PC;
        r_bd    <= keep_pc ? in_bd : 1'b0;
      end else if (w_load) begin
        r_valid <= in_valid;
        r_pc    <= in_pc;
        r_bd    <= in_bd;
        r_instr <= in_valid ? in_instr : NOP_INSTR;
        r_data  <= in_valid ? in_data : '0;
        r_exc   <= in_valid ? in_exc : 5'd0;
      end

      if (cnt_clr) begin
        r_stall_cnt  <= '0;
        r_bubble_cnt <= '0;
      end else begin
        if (w_stall_inc && r_stall_cnt != CntMax) begin
          r_stall_cnt <= r_stall_cnt + 1'b1;
        end
        if (w_bubble_inc && r_bubble_cnt != CntMax) begin
          r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
      end
    end
  end

  assign out_valid  = r_valid;
  assign out_pc     = r_pc;
  assign out_instr  = r_instr;
  assign out_data   = r_data;
  assign out_bd     = r_bd;
  assign out_exc    = r_exc;
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset, stall, flush, keep_pc, cnt_clr;
  logic        in_valid, in_bd;
  logic [31:0] in_pc, in_instr;
  logic [63:0] in_data;
  logic [4:0]  in_exc;

  logic        out_valid, out_bd;
  logic [31:0] out_pc, out_instr;
  logic [63:0] out_data;
  logic [4:0]  out_exc;
  logic [15:0] stall_cnt, bubble_cnt;

  // Narrow-counter instance for saturation checks.
  logic        s_valid, s_bd;
  logic [31:0] s_pc, s_instr;
  logic [7:0]  s_data;
  logic [4:0]  s_exc;
  logic [1:0]  s_stall_cnt, s_bubble_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .keep_pc(keep_pc),
    .cnt_clr(cnt_clr), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_data(in_data), .in_bd(in_bd), .in_exc(in_exc), .out_valid(out_valid),
    .out_pc(out_pc), .out_instr(out_instr), .out_data(out_data), .out_bd(out_bd),
    .out_exc(out_exc), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.DATA_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .keep_pc(keep_pc),
    .cnt_clr(cnt_clr), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_data(in_data[7:0]), .in_bd(in_bd), .in_exc(in_exc), .out_valid(s_valid),
    .out_pc(s_pc), .out_instr(s_instr), .out_data(s_data), .out_bd(s_bd),
    .out_exc(s_exc), .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_slot(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] ins, input logic [63:0] d, input logic bd,
                          input logic [4:0] e);
    chk({tag, ".valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".pc"}, 64'(out_pc), 64'(pc));
    chk({tag, ".instr"}, 64'(out_instr), 64'(ins));
    chk({tag, ".data"}, out_data, d);
    chk({tag, ".bd"}, 64'(out_bd), 64'(bd));
    chk({tag, ".exc"}, 64'(out_exc), 64'(e));
  endtask

  initial begin
    // Reset with arbitrary inputs, including flush and stall.
    reset = 1; stall = 1; flush = 1; keep_pc = 1; cnt_clr = 0;
    in_valid = 1; in_pc = 32'hDEAD_BEEF; in_instr = 32'h1234_5678;
    in_data = 64'hFFFF_0000_FFFF_0000; in_bd = 1; in_exc = 5'd7;
    step();
    chk_slot("reset", 0, 32'h3000, 32'h0, 64'h0, 0, 0);
    chk("reset.stall_cnt", 64'(stall_cnt), 0);
    chk("reset.bubble_cnt", 64'(bubble_cnt), 0);
    chk("reset.s_stall_cnt", 64'(s_stall_cnt), 0);

    // Plain load.
    reset = 0; stall = 0; flush = 0; keep_pc = 0;
    in_valid = 1; in_pc = 32'h3004; in_instr = 32'h2401_0001;
    in_data = 64'h0000_1234_5678_9ABC; in_bd = 0; in_exc = 0;
    step();
    chk_slot("load", 1, 32'h3004, 32'h2401_0001, 64'h0000_1234_5678_9ABC, 0, 0);

    // Stall three cycles with a new PC waiting upstream.
    stall = 1; in_pc = 32'h3008; in_instr = 32'h2402_0002; in_data = 64'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.pc", 64'(out_pc), 64'h3004);
      chk("stall.instr", 64'(out_instr), 64'h2401_0001);
    end
    chk("stall.stall_cnt", 64'(stall_cnt), 3);
    chk("stall.bubble_cnt", 64'(bubble_cnt), 0);

    // Release loads the waiting slot.
    stall = 0;
    step();
    chk_slot("release", 1, 32'h3008, 32'h2402_0002, 64'h55, 0, 0);
    chk("release.stall_cnt", 64'(stall_cnt), 3);

    // Flush keeping the PC.
    flush = 1; keep_pc = 1; in_pc = 32'h3010; in_bd = 1; in_exc = 5'd2;
    step();
    chk_slot("flush_keep", 0, 32'h3010, 32'h0, 64'h0, 1, 0);
    chk("flush_keep.bubble_cnt", 64'(bubble_cnt), 1);

    // Flush without keep_pc.
    keep_pc = 0;
    step();
    chk_slot("flush_nokeep", 0, 32'h3000, 32'h0, 64'h0, 0, 0);
    chk("flush_nokeep.bubble_cnt", 64'(bubble_cnt), 2);

    // Flush and stall together: flush wins, stall not counted.
    stall = 1;
    step();
    chk("flush_stall.valid", 64'(out_valid), 0);
    chk("flush_stall.pc", 64'(out_pc), 64'h3000);
    chk("flush_stall.stall_cnt", 64'(stall_cnt), 3);
    chk("flush_stall.bubble_cnt", 64'(bubble_cnt), 3);

    // Invalid load: payload squashed, pc/bd copied.
    stall = 0; flush = 0; in_valid = 0; in_pc = 32'h3014; in_instr = 32'hFFFF_FFFF;
    in_data = 64'hFFFF_FFFF_FFFF_FFFF; in_bd = 1; in_exc = 5'd4;
    step();
    chk_slot("invalid", 0, 32'h3014, 32'h0, 64'h0, 1, 0);
    chk("invalid.bubble_cnt", 64'(bubble_cnt), 4);

    // Valid load with exception; keep_pc is ignored without flush.
    keep_pc = 1; in_valid = 1; in_pc = 32'h3018; in_instr = 32'h0000_000C;
    in_data = 64'hA5; in_bd = 0; in_exc = 5'd8;
    step();
    chk_slot("exc_load", 1, 32'h3018, 32'h0000_000C, 64'hA5, 0, 5'd8);
    chk("exc_load.bubble_cnt", 64'(bubble_cnt), 4);

    // Reset mid-stall clears everything.
    keep_pc = 0; stall = 1; reset = 1;
    step();
    chk_slot("reset_stall", 0, 32'h3000, 32'h0, 64'h0, 0, 0);
    chk("reset_stall.stall_cnt", 64'(stall_cnt), 0);
    chk("reset_stall.bubble_cnt", 64'(bubble_cnt), 0);

    // Saturation: five stalls on the 2-bit counter.
    reset = 0;
    for (int i = 0; i < 5; i++) step();
    chk("sat.s_stall_cnt", 64'(s_stall_cnt), 3);
    chk("sat.stall_cnt", 64'(stall_cnt), 5);
    chk("sat.pc", 64'(out_pc), 64'h3000);

    // Clear during stall wins over the increment; contents unaffected.
    cnt_clr = 1;
    step();
    chk("clr.s_stall_cnt", 64'(s_stall_cnt), 0);
    chk("clr.stall_cnt", 64'(stall_cnt), 0);
    chk("clr.pc", 64'(out_pc), 64'h3000);
    cnt_clr = 0;
    step();
    chk("clr_resume.s_stall_cnt", 64'(s_stall_cnt), 1);
    chk("clr_resume.stall_cnt", 64'(stall_cnt), 1);

    // Bubble counter saturation.
    stall = 0; flush = 1;
    for (int i = 0; i < 5; i++) step();
    chk("sat.s_bubble_cnt", 64'(s_bubble_cnt), 3);
    chk("sat.bubble_cnt", 64'(bubble_cnt), 5);
    chk("sat.s_stall_after", 64'(s_stall_cnt), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
